forward_hazard_unit: RTL
========================

# forward_hazard_unit

Pipeline control block for the RV32IM five-stage core. It tracks the destination registers of instructions in flight and generates the 2-bit select codes for the EX-stage operand-A/B 4-to-1 forwarding muxes. It also detects load-use and multi-cycle MUL/DIV hazards, driving stall and bubble controls to the IF/ID and ID/EX pipeline registers. It sits beside the decoder and reads ID-stage decode fields.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width.

Ports:
- CLK  in  1  pipeline clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ID_VALID  in  1  ID holds a real instruction.
- ID_RS1, ID_RS2  in  5 each  source register addresses.
- ID_RS1_USED, ID_RS2_USED  in  1 each  instruction reads that source.
- ID_RD  in  5  destination register.
- ID_REG_WRITE  in  1  instruction writes ID_RD.
- ID_MEM_READ  in  1  instruction is a load.
- ID_MULDIV  in  1  instruction is multi-cycle DIV/DIVU/REM/REMU.
- MULDIV_DONE  in  1  the mul/div unit finishes this cycle.
- FLUSH  in  1  taken branch/jump resolved in EX; kill the ID instruction.
- FWD_SEL_A, FWD_SEL_B  out  2 each  registered operand-mux selects for the instruction in EX.
- STALL  out  1  hold the PC and IF/ID register.
- BUBBLE  out  1  load a NOP into ID/EX.

## Operation
- Shadow pipeline: entries EX, MEM, WB, each holding {valid, rd, reg_write, mem_read, muldiv}.
- Select codes:
  - 00: register file.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB writeback data.
  - 11: never driven.
- Select computation, per used source rs of the ID instruction, evaluated against the entries that will occupy MEM and WB next cycle:
  - 01 if next-MEM is valid, has reg_write, rd == rs, and rd != 0.
  - Otherwise 10 on the same test against next-WB.
  - Otherwise 00.
  - 01 takes priority when both match.
  - An unused source always gets 00.
- FSM states: RUN, MD_BUSY.
- RUN:
  - Load-use hazard: EX entry is valid with mem_read, rd != 0, and rd matches a used source of a valid ID instruction.
  - On a load-use hazard: STALL=1, BUBBLE=1; EX entry becomes invalid; MEM and WB advance.
  - Only one stall cycle is inserted, even if both sources match.
  - If EX entry is muldiv and not MULDIV_DONE: go to MD_BUSY with STALL=1.
- MD_BUSY:
  - STALL=1, BUBBLE=0; the EX entry and FWD_SEL_* hold.
  - MEM is loaded invalid; WB advances.
  - On MULDIV_DONE: STALL=0, the pipeline advances, return to RUN.
- Normal advance: ID becomes EX, EX becomes MEM, MEM becomes WB, and FWD_SEL_* load the computed selects.
- FLUSH (RUN only):
  - The next EX entry is invalid and FWD_SEL_* load 00.
  - FLUSH overrides a load-use stall: STALL=0, BUBBLE=0.
  - FLUSH is ignored in MD_BUSY.
- Whenever a bubble or invalid instruction enters EX, FWD_SEL_* load 00.
- The mul/div unit latches its operands in its first EX cycle; held selects are don't-care afterwards.

## Timing
- Reset: all entries invalid, state RUN, FWD_SEL_A/B=00, STALL=0, BUBBLE=0.
- RESET mid-stall aborts immediately to the reset state.
- STALL and BUBBLE are combinational from the current state, entries and ID inputs, valid in the same cycle as the hazard.
- FWD_SEL_* are registered: computed in the ID cycle, presented during the EX cycle (one-cycle latency).
- Load-use sequence: the load is in EX at cycle n, so stall at n. At n+1 the load is in WB-1 and the consumer advances. The consumer is in EX at n+2 with select 10.
- Back-to-back dependent ALU ops: the consumer's select is 01 in its EX cycle.

## Configuration
- MULDIV_STALL_EN defined: MD_BUSY state and ID_MULDIV/MULDIV_DONE handling are compiled in.
- Undefined: the FSM is RUN only; the muldiv bit is not stored; ID_MULDIV and MULDIV_DONE are ignored (single-cycle M-unit).

## Structure
- Shared package/header holds:
  - FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - FSM state encodings.
  - Stage-entry field layout.
- Sub-module fwd_select: combinational comparator producing one 2-bit select, instantiated twice (A, B).

## Test plan
- ADD x5 then SUB x6,x5,x1: FWD_SEL_A=01 in SUB's EX cycle, no stall.
- ADD x5; NOP; OR x7,x0,x5: FWD_SEL_B=10.
- LW x8 then ADD x9,x8,x8:
  - Exactly one cycle with STALL=1 and BUBBLE=1.
  - Then FWD_SEL_A=FWD_SEL_B=10 in ADD's EX cycle.
- ADDI x0,... then ADD using x0: selects stay 00; a load to x0 causes no stall.
- LW x8 with FLUSH=1 while the dependent instruction is in ID: STALL=0, and FWD_SEL_* are 00 in the next cycle.
- MULDIV_STALL_EN, DIV in EX:
  - STALL=1 for the four cycles until MULDIV_DONE.
  - FWD_SEL_* held throughout.
  - RESET asserted mid-busy: outputs return to 0/00 immediately.

Source files
------------

// File: rtl/forward_hazard_unit_pkg.sv
// Shared definitions for the forward/hazard unit: operand-mux select codes,
// FSM state encodings and the layout of one shadow-pipeline stage entry.
// The muldiv field only exists when MULDIV_STALL_EN is defined.
package forward_hazard_unit_pkg;

  // Operand-mux select codes; 2'b11 is never produced.
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  // Width of the rd field held in each stage entry.
  localparam int ENTRY_RD_W = 5;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } hazard_state_e;

  // One shadow-pipeline slot tracking an instruction in flight.
  typedef struct packed {
    logic                  valid;
    logic [ENTRY_RD_W-1:0] rd;
    logic                  regWrite;
    logic                  memRead;
`ifdef MULDIV_STALL_EN
    logic                  muldiv;
`endif
  } stage_entry_t;

  localparam stage_entry_t ENTRY_EMPTY = '0;

  // True when a stage entry will produce the value a source register needs.
  // x0 is hardwired to zero, so it never forwards.
  function automatic logic fwdHit(input logic                  valid,
                                  input logic                  regWrite,
                                  input logic [ENTRY_RD_W-1:0] rd,
                                  input logic [ENTRY_RD_W-1:0] rs);
    return valid && regWrite && (rd == rs) && (rd != '0);
  endfunction

endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// Operand forwarding comparator: picks the 2-bit mux select for one source
// register of the ID instruction, looking at the entries that will sit in
// MEM and WB on the next cycle. The nearer producer (MEM) wins.
module forward_hazard_unit_fwd_select
  import forward_hazard_unit_pkg::*;
(
  input  logic [ENTRY_RD_W-1:0] i_rs,
  input  logic                  i_rsUsed,
  input  logic                  i_memValid,
  input  logic                  i_memRegWrite,
  input  logic [ENTRY_RD_W-1:0] i_memRd,
  input  logic                  i_wbValid,
  input  logic                  i_wbRegWrite,
  input  logic [ENTRY_RD_W-1:0] i_wbRd,
  output logic [1:0]            o_sel
);

  // Priority compare: next-MEM producer first, then next-WB, else register file.
  always_comb begin
    o_sel = FWD_REGFILE;
    if (i_rsUsed) begin
      if (fwdHit(i_memValid, i_memRegWrite, i_memRd, i_rs)) begin
        o_sel = FWD_EXMEM;
      end else if (fwdHit(i_wbValid, i_wbRegWrite, i_wbRd, i_rs)) begin
        o_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and hazard control for the five-stage core. Keeps a shadow
// copy of the EX/MEM/WB destination info, registers operand-mux selects for
// the EX stage, and raises stall/bubble for load-use hazards.
// Define MULDIV_STALL_EN to add the MD_BUSY state that freezes EX while a
// multi-cycle divide runs; without it ID_MULDIV/MULDIV_DONE are ignored.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = ENTRY_RD_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic                  i_id_muldiv,
  input  logic                  i_muldiv_done,
  input  logic                  i_flush,
  output logic [1:0]            o_fwd_sel_a,
  output logic [1:0]            o_fwd_sel_b,
  output logic                  o_stall,
  output logic                  o_bubble
);

  stage_entry_t r_ex, r_mem, r_wb;
  stage_entry_t w_idEntry;
  logic [1:0]   r_fwdSelA, r_fwdSelB;
  logic [1:0]   w_selA, w_selB;
  logic         w_loadUse;
  logic         w_hold;
  logic         w_doFlush;
  logic         w_doBubble;
  logic         w_unusedWb;

  // Pack the ID decode fields into the entry that will move into EX.
  always_comb begin
    w_idEntry          = ENTRY_EMPTY;
    w_idEntry.valid    = i_id_valid;
    w_idEntry.rd       = i_id_rd;
    w_idEntry.regWrite = i_id_reg_write;
    w_idEntry.memRead  = i_id_mem_read;
`ifdef MULDIV_STALL_EN
    w_idEntry.muldiv   = i_id_muldiv;
`endif
  end

  // A load in EX whose result a valid ID instruction reads cannot be
  // forwarded in time, so ID must wait one cycle.
  assign w_loadUse = r_ex.valid && r_ex.memRead && (r_ex.rd != '0) && i_id_valid &&
                     ((i_id_rs1_used && (r_ex.rd == i_id_rs1)) ||
                      (i_id_rs2_used && (r_ex.rd == i_id_rs2)));

  forward_hazard_unit_fwd_select u_selA (
    .i_rs          (i_id_rs1),
    .i_rsUsed      (i_id_valid && i_id_rs1_used),
    .i_memValid    (r_ex.valid),
    .i_memRegWrite (r_ex.regWrite),
    .i_memRd       (r_ex.rd),
    .i_wbValid     (r_mem.valid),
    .i_wbRegWrite  (r_mem.regWrite),
    .i_wbRd        (r_mem.rd),
    .o_sel         (w_selA)
  );

  forward_hazard_unit_fwd_select u_selB (
    .i_rs          (i_id_rs2),
    .i_rsUsed      (i_id_valid && i_id_rs2_used),
    .i_memValid    (r_ex.valid),
    .i_memRegWrite (r_ex.regWrite),
    .i_memRd       (r_ex.rd),
    .i_wbValid     (r_mem.valid),
    .i_wbRegWrite  (r_mem.regWrite),
    .i_wbRd        (r_mem.rd),
    .o_sel         (w_selB)
  );

`ifdef MULDIV_STALL_EN
  hazard_state_e r_state, w_stateNext;

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and pipeline control; flush wins over every RUN hazard and is
  // dropped while a divide holds EX.
  always_comb begin
    w_stateNext = r_state;
    w_hold      = 1'b0;
    w_doFlush   = 1'b0;
    w_doBubble  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_flush) begin
          w_doFlush = 1'b1;
        end else if (w_loadUse) begin
          w_doBubble = 1'b1;
        end else if (r_ex.valid && r_ex.muldiv && !i_muldiv_done) begin
          w_hold      = 1'b1;
          w_stateNext = ST_MD_BUSY;
        end
      end
      ST_MD_BUSY: begin
        if (i_muldiv_done) begin
          w_stateNext = ST_RUN;
        end else begin
          w_hold = 1'b1;
        end
      end
      default: w_stateNext = ST_RUN;
    endcase
  end
`else
  logic w_unusedMuldiv;
  assign w_unusedMuldiv = ^{i_id_muldiv, i_muldiv_done};

  // Single-cycle M unit: only flush and load-use affect the pipeline.
  always_comb begin
    w_hold     = 1'b0;
    w_doFlush  = i_flush;
    w_doBubble = !i_flush && w_loadUse;
  end
`endif

  // Shadow pipeline and registered selects. A hold freezes EX and its
  // selects while MEM drains to an empty slot; a bubble or flush puts an
  // empty entry into EX with register-file selects.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ex      <= ENTRY_EMPTY;
      r_mem     <= ENTRY_EMPTY;
      r_wb      <= ENTRY_EMPTY;
      r_fwdSelA <= FWD_REGFILE;
      r_fwdSelB <= FWD_REGFILE;
    end else if (w_hold) begin
      r_mem <= ENTRY_EMPTY;
      r_wb  <= r_mem;
    end else begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_doFlush || w_doBubble) begin
        r_ex      <= ENTRY_EMPTY;
        r_fwdSelA <= FWD_REGFILE;
        r_fwdSelB <= FWD_REGFILE;
      end else begin
        r_ex      <= w_idEntry;
        r_fwdSelA <= w_selA;
        r_fwdSelB <= w_selB;
      end
    end
  end

  // The WB slot is kept for pipeline bookkeeping; writeback bypass happens
  // in the register file, so nothing reads it here.
  assign w_unusedWb = ^r_wb;

  assign o_stall     = w_hold || w_doBubble;
  assign o_bubble    = w_doBubble;
  assign o_fwd_sel_a = r_fwdSelA;
  assign o_fwd_sel_b = r_fwdSelB;

endmodule
